// File: rtl/alu_bus_pkg.sv
// Shared definitions for the ALU operand loader.
// The data width, the FSM state encoding and the released-bus value.
package alu_bus_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_A_ONLY = 2'd1,
      ST_B_ONLY = 2'd2,
      ST_BOTH   = 2'd3
   } ld_state_e;

   localparam logic [WIDTH-1:0] BUS_Z = {WIDTH{1'bz}};

endpackage

// File: rtl/operand_bus_reg.sv
// One operand register that can capture from the bus and offer its value back.
// It only offers the drive; the top level decides who actually owns the bus.
module operand_bus_reg
   import alu_bus_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         drive,
   input  logic [W-1:0] bus_in,
   output logic [W-1:0] value,
   output logic [W-1:0] drv_val,
   output logic         drv_en
);

   logic [W-1:0] val_d, val_q;

   // Loading while driving would only read back our own value, so just hold.
   always_comb begin
      val_d = val_q;
      if (load && !drive) begin
         val_d = bus_in;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign value   = val_q;
   assign drv_val = val_q;
   assign drv_en  = drive & ~clr;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures ALU operands from the shared bus and tracks when a full pair is ready.
// Also resolves the two register drivers onto the bus and flags misuse.
module alu_operand_loader
   import alu_bus_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             load_a,
   input  logic             load_b,
   input  logic             out_a,
   input  logic             out_b,
   input  logic             alu_take,
   inout  wire [WIDTH-1:0]  bus_io,
   output logic [WIDTH-1:0] reg_A,
   output logic [WIDTH-1:0] reg_B,
   output logic             ops_valid,
   output logic             b_zero,
   output logic             bus_err,
   output logic             take_err
);

   logic [WIDTH-1:0] a_drv, b_drv;
   logic             a_en, b_en;
   logic             sel_a, sel_b;

   ld_state_e state_d, state_q;
   logic      bus_err_d, bus_err_q;
   logic      take_err_d, take_err_q;

   operand_bus_reg #(.W(WIDTH)) u_reg_a (
      .clk     (clk),
      .clr     (clr),
      .load    (load_a),
      .drive   (out_a),
      .bus_in  (bus_io),
      .value   (reg_A),
      .drv_val (a_drv),
      .drv_en  (a_en)
   );

   operand_bus_reg #(.W(WIDTH)) u_reg_b (
      .clk     (clk),
      .clr     (clr),
      .load    (load_b),
      .drive   (out_b),
      .bus_in  (bus_io),
      .value   (reg_B),
      .drv_val (b_drv),
      .drv_en  (b_en)
   );

   assign sel_a  = a_en & ~b_en;
   assign sel_b  = b_en & ~a_en;
   assign bus_io = sel_a ? a_drv : (sel_b ? b_drv : BUS_Z);

   always_comb begin
      state_d    = state_q;
      bus_err_d  = bus_err_q | (out_a & out_b);
      take_err_d = take_err_q | (alu_take & (state_q != ST_BOTH));
      unique case (state_q)
         ST_EMPTY: begin
            if (load_a && load_b) state_d = ST_BOTH;
            else if (load_a)      state_d = ST_A_ONLY;
            else if (load_b)      state_d = ST_B_ONLY;
         end
         ST_A_ONLY: begin
            if (load_b) state_d = ST_BOTH;
         end
         ST_B_ONLY: begin
            if (load_a) state_d = ST_BOTH;
         end
         ST_BOTH: begin
            // A consume frees the pair; same-cycle loads start the next one.
            if (alu_take) begin
               if (load_a && load_b) state_d = ST_BOTH;
               else if (load_a)      state_d = ST_A_ONLY;
               else if (load_b)      state_d = ST_B_ONLY;
               else                  state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= ST_EMPTY;
         bus_err_q  <= 1'b0;
         take_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bus_err_q  <= bus_err_d;
         take_err_q <= take_err_d;
      end
   end

   assign ops_valid = (state_q == ST_BOTH);
   assign b_zero    = (reg_B == '0);
   assign bus_err   = bus_err_q;
   assign take_err  = take_err_q;

endmodule
